// File: rtl/instruction_memory_pkg.sv
// Shared fetch-path definitions: responder state encoding, NOP filler word and
// fault reason codes kept for later trap handling.
package instruction_memory_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    typedef enum logic [1:0] {
        FLT_NONE         = 2'd0,
        FLT_MISALIGNED   = 2'd1,
        FLT_BELOW_BASE   = 2'd2,
        FLT_OUT_OF_RANGE = 2'd3
    } fetch_fault_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one program-load write port and one read-first read port
// whose output register holds its value until the next read.
module imem_array
    import instruction_memory_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];
    logic [INSTR_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-edge write lands after this read, giving read-first behaviour.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory.sv
// Fetch responder: accepts one byte address, checks alignment/range and returns
// the instruction word (or a NOP with ERR) after a fixed latency, held until RACK.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 64,
    parameter int unsigned            DEPTH_WORDS = 1024,
    parameter int unsigned            LATENCY     = 2,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           REQ,
    input  logic [ADDR_WIDTH-1:0]          ADDR,
    output logic                           READY,
    output logic                           RVALID,
    output logic [INSTR_W-1:0]             RDATA,
    output logic                           ERR,
    input  logic                           RACK,
    input  logic                           PROG_WE,
    input  logic [$clog2(DEPTH_WORDS)-1:0] PROG_ADDR,
    input  logic [INSTR_W-1:0]             PROG_DATA
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    imem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic                  fault_q, fault_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;

    logic [ADDR_WIDTH-1:0] off_c;
    fetch_fault_e          fault_rsn_c;
    logic                  sample_c;
    logic [INSTR_W-1:0]    ram_rdata;

    // Fault classification of the incoming address, used only on accept.
    always_comb begin
        off_c = ADDR - BASE_ADDR;
        if (ADDR[1:0] != 2'b00) begin
            fault_rsn_c = FLT_MISALIGNED;
        end else if (ADDR < BASE_ADDR) begin
            fault_rsn_c = FLT_BELOW_BASE;
        end else if ((off_c >> 2) >= ADDR_WIDTH'(DEPTH_WORDS)) begin
            fault_rsn_c = FLT_OUT_OF_RANGE;
        end else begin
            fault_rsn_c = FLT_NONE;
        end
    end

    assign sample_c = (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        fault_d  = fault_q;
        err_d    = err_q;
        ready_d  = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    widx_d  = IDX_W'(off_c >> 2);
                    fault_d = (fault_rsn_c != FLT_NONE);
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    err_d   = fault_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (RACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d  = (state_d == ST_IDLE);
        rvalid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            widx_q   <= '0;
            fault_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            fault_q  <= fault_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (PROG_WE && !RST),
        .waddr_i (PROG_ADDR),
        .wdata_i (PROG_DATA),
        .re_i    (sample_c && !fault_q && !RST),
        .raddr_i (widx_q),
        .rdata_o (ram_rdata)
    );

    // Faulted fetches never read the array; the NOP is substituted from flops.
    assign READY  = ready_q;
    assign RVALID = rvalid_q;
    assign ERR    = err_q;
    assign RDATA  = err_q ? NOP_INSTR : ram_rdata;

endmodule

// File: tb/tb_instruction_memory.sv
// Two responders (base 0 / latency 2, base 0x1000 / latency 1) share one stimulus
// stream; a reference model fills per-DUT queues that independent monitors drain.
module tb_instruction_memory;
    import instruction_memory_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 1;
    localparam logic [63:0] BASE0 = 64'h0;
    localparam logic [63:0] BASE1 = 64'h1000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        CLK, RST, REQ, RACK, PROG_WE;
    logic [63:0] ADDR;
    logic [9:0]  PROG_ADDR;
    logic [31:0] PROG_DATA;
    logic        ready0, rvalid0, err0, ready1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;

    instruction_memory #(.ADDR_WIDTH(64), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0), .BASE_ADDR(BASE0)) dut0 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .READY(ready0), .RVALID(rvalid0),
        .RDATA(rdata0), .ERR(err0), .RACK(RACK), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR),
        .PROG_DATA(PROG_DATA));

    instruction_memory #(.ADDR_WIDTH(64), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1), .BASE_ADDR(BASE1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .READY(ready1), .RVALID(rvalid1),
        .RDATA(rdata1), .ERR(err1), .RACK(RACK), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR),
        .PROG_DATA(PROG_DATA));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [DEPTH];
    resp_t       exp_q0[$];
    resp_t       exp_q1[$];
    bit          m_busy [2];
    bit          m_done [2];
    int          m_sample [2];
    logic [63:0] m_addr [2];
    bit          m_rst_last = 1'b0;
    int          cyc = 0;
    resp_t       cur [2];
    bit          prev_valid [2];

    // Expected response from the address rules alone.
    function automatic resp_t model_resp(logic [63:0] a, logic [63:0] base);
        resp_t       r;
        logic [63:0] word;
        if ((a % 64'd4) != 64'd0 || a < base || (a - base) / 64'd4 >= 64'(DEPTH)) begin
            r.data = NOP_INSTR;
            r.err  = 1'b1;
        end else begin
            word   = (a - base) / 64'd4;
            r.data = mem_m[word[9:0]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // Reference model: per-DUT transaction bookkeeping, memory read before same-edge write.
    always @(posedge CLK) begin
        cyc        = cyc + 1;
        m_rst_last = RST;
        if (RST) begin
            m_busy[0] = 1'b0;
            m_busy[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k]) begin
                    if (!m_done[k] && cyc == m_sample[k]) begin
                        if (k == 0) exp_q0.push_back(model_resp(m_addr[0], BASE0));
                        else        exp_q1.push_back(model_resp(m_addr[1], BASE1));
                        m_done[k] = 1'b1;
                    end else if (m_done[k] && RACK) begin
                        m_busy[k] = 1'b0;
                    end
                end else if (REQ) begin
                    m_busy[k]   = 1'b1;
                    m_done[k]   = 1'b0;
                    m_addr[k]   = ADDR;
                    m_sample[k] = cyc + ((k == 0) ? LAT0 : LAT1);
                end
            end
            if (PROG_WE) mem_m[PROG_ADDR] = PROG_DATA;
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic r, input logic [31:0] d, input logic e);
        chk("ready", k, 32'(r), 32'(!m_busy[k]));
        chk("rvalid", k, 32'(v), 32'(m_busy[k] && m_done[k]));
        if (m_rst_last) begin
            chk("rst_rdata", k, d, 32'h0);
            chk("rst_err", k, 32'(e), 32'h0);
        end
        if (v) begin
            if (!prev_valid[k]) begin
                if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got data %h err %0b, required none", k, d, e);
                    cur[k] = '{data: d, err: e};
                end else begin
                    cur[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                end
            end
            chk("rdata", k, d, cur[k].data);
            chk("err", k, 32'(e), 32'(cur[k].err));
        end
        prev_valid[k] = v;
    endtask

    always @(negedge CLK) begin
        mon(0, rvalid0, ready0, rdata0, err0);
        mon(1, rvalid1, ready1, rdata1, err1);
    end

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic prog(input logic [9:0] idx, input logic [31:0] data);
        PROG_WE   = 1'b1;
        PROG_ADDR = idx;
        PROG_DATA = data;
        @(negedge CLK);
        PROG_WE = 1'b0;
    endtask

    // One fetch on both DUTs; optional program write wr_at cycles after accept+1; hold RESP for 'hold' cycles.
    task automatic fetch(input logic [63:0] a, input int hold, input int wr_at,
                         input logic [9:0] widx, input logic [31:0] wdata);
        bit ok;
        REQ  = 1'b1;
        ADDR = a;
        @(negedge CLK);
        REQ = 1'b0;
        if (wr_at >= 0) begin
            repeat (wr_at) @(negedge CLK);
            prog(widx, wdata);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid0 && rvalid1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout addr %h: rvalid0=%0b rvalid1=%0b, required both 1", a, rvalid0, rvalid1);
        end
        for (int i = 0; i < hold; i++) begin
            REQ  = 1'($urandom_range(0, 1));
            ADDR = {$urandom, $urandom};
            @(negedge CLK);
        end
        REQ  = 1'b0;
        RACK = 1'b1;
        @(negedge CLK);
        RACK = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        int          sel, wr_at;

        RST = 1'b1; REQ = 1'b0; RACK = 1'b0; PROG_WE = 1'b0;
        ADDR = '0; PROG_ADDR = '0; PROG_DATA = '0;
        do_reset();

        for (int i = 0; i < 64; i++) prog(10'(i), $urandom);
        prog(10'd1023, 32'hC0DE_03FF);

        prog(10'd3, 32'h0050_0093);
        fetch(64'hC, 0, -1, '0, '0);

        prog(10'd5, 32'h5555_1234);
        do_reset();
        fetch(64'h14, 0, -1, '0, '0);

        fetch(64'h6, 0, -1, '0, '0);
        fetch(64'(4 * DEPTH), 0, -1, '0, '0);
        fetch(64'hFFC, 0, -1, '0, '0);
        fetch(64'h100C, 1, -1, '0, '0);
        fetch(BASE1 + 64'(4 * DEPTH), 0, -1, '0, '0);

        fetch(64'h10, 4, -1, '0, '0);

        prog(10'd7, 32'hAAAA_0000);
        fetch(64'h1C, 0, 0, 10'd7, 32'h1234_5678);
        prog(10'd7, 32'hAAAA_0000);
        fetch(64'h1C, 0, 1, 10'd7, 32'h8765_4321);

        // Abort an in-flight fetch with reset, then confirm normal service resumes.
        REQ  = 1'b1;
        ADDR = 64'hC;
        @(negedge CLK);
        REQ = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        fetch(64'h1C, 0, -1, '0, '0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 5: a = 64'(4 * $urandom_range(0, 63));
                1:    a = BASE1 + 64'(4 * $urandom_range(0, 63));
                2:    a = 64'(4 * $urandom_range(0, 2000)) + 64'($urandom_range(1, 3));
                3:    a = BASE1 + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 100));
                default: a = 64'hFFFF_FFFF_FFFF_FFF0 - 64'(4 * $urandom_range(0, 15));
            endcase
            wr_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 2));
            fetch(a, int'($urandom_range(0, 4)), wr_at, 10'($urandom_range(0, 63)), $urandom);
        end

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d/%0d pending, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
